lea_round_unit: RTL and testbench

- Handshaked, sequential LEA round engine. Successor to the 32-bit combinational block-addition primitive (XOR with round key, then modular add).
- Applies one complete LEA round to a 4-word state with a 6-word round key.
- Supports both encryption (forward) and decryption (inverse) via a per-transaction mode bit.
- Sits between the round-key scheduler and the round-iteration controller. Word width and rotation amounts are parameters.

---
 rtl/lea_pkg.sv | 41 ++++
 rtl/lea_word_mix.sv | 21 ++
 rtl/lea_round_unit.sv | 170 +++++++++++++++++
 tb/tb_lea_round_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lea_pkg.sv
// Shared definitions for the LEA round engine: widths, rotation amounts, FSM states
// and the width-generic rotate and word-extraction helpers.
package lea_pkg;

    localparam int LEA_W     = 32;
    localparam int LEA_ROT_A = 9;
    localparam int LEA_ROT_B = 5;
    localparam int LEA_ROT_C = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CALC1 = 3'd2,
        CALC2 = 3'd3,
        CALC3 = 3'd4,
        HOLD  = 3'd5
    } lea_state_e;

    // Rotates operate on a 64-bit carrier so one function serves any W below 64.
    function automatic logic [63:0] width_mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] rol(input logic [63:0] v, input int w, input int r);
        logic [63:0] m;
        m = v & width_mask(w);
        return ((m << r) | (m >> (w - r))) & width_mask(w);
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int w, input int r);
        logic [63:0] m;
        m = v & width_mask(w);
        return ((m >> r) | (m << (w - r))) & width_mask(w);
    endfunction

    // Word idx of a packed bus holding up to six 64-bit-or-narrower words.
    function automatic logic [63:0] word_at(input logic [383:0] bus, input int w, input int idx);
        return (bus >> (idx * w)) & width_mask(w);
    endfunction

endpackage

// File: rtl/lea_word_mix.sv
// Combinational (a^k0) +/- (b^k1) modulo 2^W; sub selects subtraction.
// Zero latency, no flow control.
module lea_word_mix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] k0,
    input  logic [W-1:0] b,
    input  logic [W-1:0] k1,
    input  logic         sub,
    output logic [W-1:0] y
);

    logic [W-1:0] lhs;
    logic [W-1:0] rhs;

    assign lhs = a ^ k0;
    assign rhs = b ^ k1;
    assign y   = sub ? (lhs - rhs) : (lhs + rhs);

endmodule

// File: rtl/lea_round_unit.sv
// One LEA round (forward or inverse) on a 4-word state; OutValid 2 cycles after accept
// for encrypt, 5 for decrypt. Single transaction in flight; Result held until OutReady.
module lea_round_unit
    import lea_pkg::*;
#(
    parameter int W     = LEA_W,
    parameter int ROT_A = LEA_ROT_A,
    parameter int ROT_B = LEA_ROT_B,
    parameter int ROT_C = LEA_ROT_C
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         InValid,
    output logic         InReady,
    input  logic         Decrypt,
    input  logic [4*W-1:0] Block,
    input  logic [6*W-1:0] RoundKey,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [4*W-1:0] Result
);

    lea_state_e state_q, state_d;

    logic [W-1:0]   x_q  [4];
    logic [W-1:0]   rk_q [6];
    logic [W-1:0]   z_q  [4];
    logic           dec_q;
    logic [4*W-1:0] result_q;
    logic           out_vld_q;

    logic [W-1:0] mix_a, mix_k0, mix_b, mix_k1, mix_y;
    logic         mix_sub;
    logic [W-1:0] lane1_y, lane2_y;

    assign InReady  = (state_q == IDLE) && !RST;
    assign OutValid = out_vld_q;
    assign Result   = result_q;

    // Shared mixer: first encrypt lane in LOAD, the single subtract of each decrypt step.
    always_comb begin
        mix_a   = x_q[0];
        mix_k0  = rk_q[0];
        mix_b   = x_q[1];
        mix_k1  = rk_q[1];
        mix_sub = 1'b0;
        case (state_q)
            CALC1: begin
                mix_a   = W'(ror(64'(x_q[0]), W, ROT_A));
                mix_k0  = '0;
                mix_b   = z_q[0];
                mix_k1  = rk_q[0];
                mix_sub = 1'b1;
            end
            CALC2: begin
                mix_a   = W'(rol(64'(x_q[1]), W, ROT_B));
                mix_k0  = '0;
                mix_b   = z_q[1];
                mix_k1  = rk_q[2];
                mix_sub = 1'b1;
            end
            CALC3: begin
                mix_a   = W'(rol(64'(x_q[2]), W, ROT_C));
                mix_k0  = '0;
                mix_b   = z_q[2];
                mix_k1  = rk_q[4];
                mix_sub = 1'b1;
            end
            default: ;
        endcase
    end

    lea_word_mix #(.W(W)) u_mix (
        .a   (mix_a),
        .k0  (mix_k0),
        .b   (mix_b),
        .k1  (mix_k1),
        .sub (mix_sub),
        .y   (mix_y)
    );

    // Remaining forward lanes must all resolve in the single LOAD cycle.
    lea_word_mix #(.W(W)) u_mix_lane1 (
        .a   (x_q[1]),
        .k0  (rk_q[2]),
        .b   (x_q[2]),
        .k1  (rk_q[3]),
        .sub (1'b0),
        .y   (lane1_y)
    );

    lea_word_mix #(.W(W)) u_mix_lane2 (
        .a   (x_q[2]),
        .k0  (rk_q[4]),
        .b   (x_q[3]),
        .k1  (rk_q[5]),
        .sub (1'b0),
        .y   (lane2_y)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (InValid) state_d = LOAD;
            LOAD:    state_d = dec_q ? CALC1 : HOLD;
            CALC1:   state_d = CALC2;
            CALC2:   state_d = CALC3;
            CALC3:   state_d = HOLD;
            HOLD:    if (out_vld_q && OutReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= '0;
                z_q[i] <= '0;
            end
            for (int j = 0; j < 6; j++) begin
                rk_q[j] <= '0;
            end
            dec_q     <= 1'b0;
            result_q  <= '0;
            out_vld_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (InValid) begin
                        for (int i = 0; i < 4; i++) x_q[i] <= Block[i*W +: W];
                        for (int j = 0; j < 6; j++) rk_q[j] <= RoundKey[j*W +: W];
                        dec_q <= Decrypt;
                    end
                end
                LOAD: begin
                    if (dec_q) begin
                        z_q[0] <= x_q[3];
                    end else begin
                        z_q[0] <= W'(rol(64'(mix_y), W, ROT_A));
                        z_q[1] <= W'(ror(64'(lane1_y), W, ROT_B));
                        z_q[2] <= W'(ror(64'(lane2_y), W, ROT_C));
                        z_q[3] <= x_q[0];
                    end
                end
                CALC1: z_q[1] <= mix_y ^ rk_q[1];
                CALC2: z_q[2] <= mix_y ^ rk_q[3];
                CALC3: z_q[3] <= mix_y ^ rk_q[5];
                HOLD: begin
                    // First HOLD cycle publishes the result; it then stays frozen until taken.
                    if (!out_vld_q) begin
                        result_q  <= {z_q[3], z_q[2], z_q[1], z_q[0]};
                        out_vld_q <= 1'b1;
                    end else if (OutReady) begin
                        out_vld_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lea_round_unit.sv
// Randomised and directed checks of lea_round_unit against a word-level LEA round model.
module tb_lea_round_unit;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         InValid = 1'b0;
    logic         InReady;
    logic         Decrypt = 1'b0;
    logic [127:0] Block = '0;
    logic [191:0] RoundKey = '0;
    logic         OutValid;
    logic         OutReady = 1'b0;
    logic [127:0] Result;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 CLK = ~CLK;

    lea_round_unit #(.W(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .InValid  (InValid),
        .InReady  (InReady),
        .Decrypt  (Decrypt),
        .Block    (Block),
        .RoundKey (RoundKey),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result)
    );

    function automatic logic [31:0] rl(input logic [31:0] v, input int r);
        return (v << r) | (v >> (32 - r));
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] v, input int r);
        return (v >> r) | (v << (32 - r));
    endfunction

    function automatic logic [127:0] model_round(input bit dec, input logic [127:0] b, input logic [191:0] k);
        logic [31:0] x [4];
        logic [31:0] rk [6];
        logic [31:0] o [4];
        logic [31:0] s;
        for (int i = 0; i < 4; i++) x[i] = b[i*32 +: 32];
        for (int j = 0; j < 6; j++) rk[j] = k[j*32 +: 32];
        if (!dec) begin
            s = (x[0] ^ rk[0]) + (x[1] ^ rk[1]); o[0] = rl(s, 9);
            s = (x[1] ^ rk[2]) + (x[2] ^ rk[3]); o[1] = rr(s, 5);
            s = (x[2] ^ rk[4]) + (x[3] ^ rk[5]); o[2] = rr(s, 3);
            o[3] = x[0];
        end else begin
            o[0] = x[3];
            s = rr(x[0], 9) - (o[0] ^ rk[0]); o[1] = s ^ rk[1];
            s = rl(x[1], 5) - (o[1] ^ rk[2]); o[2] = s ^ rk[3];
            s = rl(x[2], 3) - (o[2] ^ rk[4]); o[3] = s ^ rk[5];
        end
        return {o[3], o[2], o[1], o[0]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [191:0] rand192();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Runs one transaction from IDLE; lat is -1 if OutValid never rose.
    task automatic do_txn(input bit dec, input logic [127:0] blk, input logic [191:0] key,
                          input int ready_delay, output logic [127:0] res, output int lat);
        int guard;
        guard = 0;
        lat = -1;
        res = '0;
        Decrypt = dec; Block = blk; RoundKey = key; InValid = 1'b1;
        while (!InReady && guard < 20) begin
            @(posedge CLK); #1; guard++;
        end
        @(posedge CLK); #1;
        InValid = 1'b0; Decrypt = $urandom_range(0, 1); Block = rand128(); RoundKey = rand192();
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (OutValid) begin
                lat = i;
                break;
            end
        end
        res = Result;
        for (int i = 0; i < ready_delay; i++) begin
            @(posedge CLK); #1;
        end
        OutReady = 1'b1;
        @(posedge CLK); #1;
        OutReady = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        total_cnt++; if (InReady !== 1'b0) $display("FAIL reset_inready got %b want 0", InReady); else pass_cnt++;
        total_cnt++; if (OutValid !== 1'b0) $display("FAIL reset_outvalid got %b want 0", OutValid); else pass_cnt++;
        RST = 1'b0;
        #1;
        total_cnt++; if (InReady !== 1'b1) $display("FAIL idle_inready got %b want 1", InReady); else pass_cnt++;
        total_cnt++; if (Result !== 128'd0) $display("FAIL idle_result got %h want 0", Result); else pass_cnt++;
        @(posedge CLK); #1;
    endtask

    task automatic test_encrypt_zero_key();
        logic [127:0] res; int lat;
        do_txn(1'b0, {96'd0, 32'd1}, 192'd0, 0, res, lat);
        total_cnt++; if (res !== {32'h1, 32'h0, 32'h0, 32'h200}) $display("FAIL enc_zero_key got %h want %h", res, {32'h1, 64'h0, 32'h200}); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("FAIL enc_latency got %0d want 2", lat); else pass_cnt++;
    endtask

    task automatic test_encrypt_wrap();
        logic [127:0] res; int lat;
        do_txn(1'b0, 128'd0, {128'd0, 32'hEC489E49, 32'h23820809}, 1, res, lat);
        total_cnt++; if (res !== {96'd0, 32'h954CA41F}) $display("FAIL enc_carry_wrap got %h want %h", res, {96'd0, 32'h954CA41F}); else pass_cnt++;
    endtask

    task automatic test_decrypt_roundtrip();
        logic [127:0] res, enc, p; logic [191:0] k; int lat;
        do_txn(1'b1, {96'd0, 32'h954CA41F}, {128'd0, 32'hEC489E49, 32'h23820809}, 0, res, lat);
        total_cnt++; if (res !== 128'd0) $display("FAIL dec_carry_wrap got %h want 0", res); else pass_cnt++;
        total_cnt++; if (lat !== 5) $display("FAIL dec_latency got %0d want 5", lat); else pass_cnt++;
        do_txn(1'b1, {32'h1, 64'd0, 32'h200}, 192'd0, 0, res, lat);
        total_cnt++; if (res !== {96'd0, 32'd1}) $display("FAIL dec_zero_key got %h want %h", res, {96'd0, 32'd1}); else pass_cnt++;
        for (int n = 0; n < 8; n++) begin
            p = rand128(); k = rand192();
            do_txn(1'b0, p, k, $urandom_range(0, 2), enc, lat);
            do_txn(1'b1, enc, k, $urandom_range(0, 2), res, lat);
            total_cnt++; if (res !== p) $display("FAIL roundtrip_%0d got %h want %h", n, res, p); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [127:0] res, p; logic [191:0] k; int lat; bit d;
        for (int n = 0; n < 20; n++) begin
            d = 1'($urandom_range(0, 1)); p = rand128(); k = rand192();
            do_txn(d, p, k, $urandom_range(0, 3), res, lat);
            total_cnt++; if (res !== model_round(d, p, k)) $display("FAIL random_%0d dec=%0b got %h want %h", n, d, res, model_round(d, p, k)); else pass_cnt++;
            total_cnt++; if (lat !== (d ? 5 : 2)) $display("FAIL random_lat_%0d got %0d want %0d", n, lat, d ? 5 : 2); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] p1, p2, exp1, exp2, res; logic [191:0] k1, k2; int lat; bit stable;
        p1 = rand128(); k1 = rand192(); p2 = rand128(); k2 = rand192();
        exp1 = model_round(1'b0, p1, k1); exp2 = model_round(1'b1, p2, k2);
        Decrypt = 1'b0; Block = p1; RoundKey = k1; InValid = 1'b1;
        @(posedge CLK); #1;
        Decrypt = 1'b1; Block = p2; RoundKey = k2;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (OutValid) begin lat = i; break; end
        end
        total_cnt++; if (lat !== 2) $display("FAIL bp_first_latency got %0d want 2", lat); else pass_cnt++;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (OutValid !== 1'b1 || Result !== exp1 || InReady !== 1'b0) stable = 1'b0;
        end
        total_cnt++; if (stable !== 1'b1) $display("FAIL bp_hold got unstable want stable (res %h exp %h)", Result, exp1); else pass_cnt++;
        OutReady = 1'b1;
        @(posedge CLK); #1;
        OutReady = 1'b0;
        total_cnt++; if (OutValid !== 1'b0) $display("FAIL bp_release_outvalid got %b want 0", OutValid); else pass_cnt++;
        total_cnt++; if (InReady !== 1'b1) $display("FAIL bp_release_inready got %b want 1", InReady); else pass_cnt++;
        @(posedge CLK); #1;
        InValid = 1'b0;
        total_cnt++; if (InReady !== 1'b0) $display("FAIL bp_second_accept got inready %b want 0", InReady); else pass_cnt++;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (OutValid) begin lat = i; break; end
        end
        res = Result;
        total_cnt++; if (res !== exp2 || lat !== 5) $display("FAIL bp_second_txn got %h lat %0d want %h lat 5", res, lat, exp2); else pass_cnt++;
        OutReady = 1'b1;
        @(posedge CLK); #1;
        OutReady = 1'b0;
    endtask

    task automatic test_reset_mid_decrypt();
        logic [127:0] res, p; logic [191:0] k; int lat; bit quiet;
        Decrypt = 1'b1; Block = rand128(); RoundKey = rand192(); InValid = 1'b1;
        @(posedge CLK); #1;
        InValid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        total_cnt++; if (InReady !== 1'b0 || OutValid !== 1'b0) $display("FAIL midrst_outputs got inready %b outvalid %b want 0 0", InReady, OutValid); else pass_cnt++;
        @(posedge CLK); #1;
        RST = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (OutValid !== 1'b0) quiet = 1'b0;
        end
        total_cnt++; if (quiet !== 1'b1) $display("FAIL midrst_dropped got outvalid rise want none"); else pass_cnt++;
        total_cnt++; if (Result !== 128'd0 || InReady !== 1'b1) $display("FAIL midrst_idle got res %h inready %b want 0 1", Result, InReady); else pass_cnt++;
        p = rand128(); k = rand192();
        do_txn(1'b1, p, k, 0, res, lat);
        total_cnt++; if (res !== model_round(1'b1, p, k) || lat !== 5) $display("FAIL midrst_next got %h lat %0d want %h lat 5", res, lat, model_round(1'b1, p, k)); else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_encrypt_zero_key();
        test_encrypt_wrap();
        test_decrypt_roundtrip();
        test_random();
        test_back_to_back();
        test_reset_mid_decrypt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
